grant_bus_ctrl: RTL

GRANT_BUS_CTRL -- requirements
Module: grant_bus_ctrl

---
 rtl/grant_bus_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/grant_bus_ctrl.sv
// Shared-bus controller: forwards words from the granted requester of a 3-way arbiter,
// with valid/ready backpressure, per-grant burst limiting and a sticky bad-grant flag.
module grant_bus_ctrl #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:3] g,
    input  logic [1:3] v,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:3] ack,
    output logic [1:3] burst_done,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        HOLD
    } state_t;

    state_t           state;
    logic [1:0]       owner;
    logic [CNT_W-1:0] cnt;

    logic             g_own;
    logic             v_own;
    logic [7:0]       d_own;
    logic [1:3]       own_vec;
    logic             g_multi;
    logic             g_single;
    logic [1:0]       g_idx;
    logic [CNT_W-1:0] cnt_next;

    // Owner-indexed views of the request inputs; feed registers only.
    always_comb begin
        g_own   = 1'b0;
        v_own   = 1'b0;
        d_own   = 8'h00;
        own_vec = 3'b000;
        case (owner)
            2'd1: begin g_own = g[1]; v_own = v[1]; d_own = d1; own_vec = 3'b100; end
            2'd2: begin g_own = g[2]; v_own = v[2]; d_own = d2; own_vec = 3'b010; end
            2'd3: begin g_own = g[3]; v_own = v[3]; d_own = d3; own_vec = 3'b001; end
            default: ;
        endcase
    end

    // Grant decode: multi-bit grants are illegal; single grants yield the owner index.
    always_comb begin
        g_multi  = (g[1] & g[2]) | (g[1] & g[3]) | (g[2] & g[3]);
        g_single = (|g) & ~g_multi;
        if (g[1]) begin
            g_idx = 2'd1;
        end else if (g[2]) begin
            g_idx = 2'd2;
        end else begin
            g_idx = 2'd3;
        end
        cnt_next = cnt + CNT_W'(1);
    end

    // Controller FSM with registered outputs; ack/burst_done are single-cycle pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            owner      <= 2'd1;
            cnt        <= '0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            ack        <= 3'b000;
            burst_done <= 3'b000;
            err        <= 1'b0;
        end else begin
            ack        <= 3'b000;
            burst_done <= 3'b000;
            case (state)
                IDLE: begin
                    if (g_multi) begin
                        err <= 1'b1;
                    end else if (g_single) begin
                        owner <= g_idx;
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!g_own) begin
                        state <= IDLE;
                    end else if (v_own) begin
                        out_data  <= d_own;
                        out_valid <= 1'b1;
                        ack       <= own_vec;
                        state     <= SEND;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                SEND: begin
                    // A presented word always completes, even if the grant has gone.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= cnt_next;
                        if (cnt_next == CNT_LAST) begin
                            burst_done <= own_vec;
                            state      <= HOLD;
                        end else if (g_own) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    out_valid <= 1'b0;
                    if (!g_own) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pulses are at most one-hot and only ever name the current owner.
    a_pulse_onehot: assert property (@(posedge Clock) disable iff (Reset)
        $onehot0(ack) && $onehot0(burst_done));
    a_pulse_owner: assert property (@(posedge Clock) disable iff (Reset)
        ((ack | burst_done) & ~own_vec) == 3'b000);

endmodule
